// File: rtl/sdc_pkg.sv
// Shared constants for the SPI SD card sequencers: state encoding, command
// opcodes, data-path tokens and error codes.
package sdc_pkg;

    typedef logic [3:0] sdc_state_t;

    localparam sdc_state_t ST_IDLE      = 4'd0;
    localparam sdc_state_t ST_CMD       = 4'd1;
    localparam sdc_state_t ST_CMD_WAIT  = 4'd2;
    localparam sdc_state_t ST_R1_WAIT   = 4'd3;
    localparam sdc_state_t ST_TOK_WAIT  = 4'd4;
    localparam sdc_state_t ST_DATA_WAIT = 4'd5;
    localparam sdc_state_t ST_CRC_WAIT  = 4'd6;
    localparam sdc_state_t ST_DONE      = 4'd7;
    localparam sdc_state_t ST_ERR       = 4'd8;

    // Command opcodes with the 0b01 start/transmission prefix already applied.
    localparam logic [7:0] SD_CMD0   = 8'h40;
    localparam logic [7:0] SD_CMD8   = 8'h48;
    localparam logic [7:0] SD_CMD17  = 8'h51;
    localparam logic [7:0] SD_CMD24  = 8'h58;
    localparam logic [7:0] SD_CMD55  = 8'h77;
    localparam logic [7:0] SD_CMD58  = 8'h7A;
    localparam logic [7:0] SD_ACMD41 = 8'h69;

    localparam logic [7:0] SD_TOKEN_START = 8'hFE;
    localparam logic [7:0] SD_IDLE_BYTE   = 8'hFF;
    localparam logic [7:0] SD_R1_READY    = 8'h00;

    typedef logic [2:0] sdc_err_t;

    localparam sdc_err_t ERR_NONE        = 3'd0;
    localparam sdc_err_t ERR_NOT_INIT    = 3'd1;
    localparam sdc_err_t ERR_BAD_R1      = 3'd2;
    localparam sdc_err_t ERR_R1_TIMEOUT  = 3'd3;
    localparam sdc_err_t ERR_DATA_TOKEN  = 3'd4;
    localparam sdc_err_t ERR_TOK_TIMEOUT = 3'd5;

endpackage

// File: rtl/sdc_poll_cnt.sv
// Shared poll/byte counter; the *_last flags say the next increment lands
// exactly on the matching limit.
module sdc_poll_cnt
    import sdc_pkg::*;
#(
    parameter int unsigned R1_TRIES    = 8,
    parameter int unsigned TOKEN_TRIES = 4096,
    parameter int unsigned BLOCK_LEN   = 512,
    parameter int unsigned CNT_W       = 13
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_r1_last,
    output logic             o_tok_last,
    output logic             o_blk_last
);

    logic [CNT_W-1:0] cnt_nxt;

    assign cnt_nxt = o_cnt + CNT_W'(1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_cnt <= '0;
        end else if (i_clr) begin
            o_cnt <= '0;
        end else if (i_inc) begin
            o_cnt <= cnt_nxt;
        end
    end

    assign o_r1_last  = (cnt_nxt == CNT_W'(R1_TRIES));
    assign o_tok_last = (cnt_nxt == CNT_W'(TOKEN_TRIES));
    assign o_blk_last = (cnt_nxt == CNT_W'(BLOCK_LEN));

endmodule

// File: rtl/sdc_read_ctrl.sv
// CMD17 single-block read sequencer: drives the command and receive engines,
// streams the data bytes out and reports done or a coded error.
module sdc_read_ctrl
    import sdc_pkg::*;
#(
    parameter int unsigned R1_TRIES    = 8,
    parameter int unsigned TOKEN_TRIES = 4096,
    parameter int unsigned BLOCK_LEN   = 512,
    parameter int unsigned CNT_W       = 13
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [31:0] i_addr,
    input  logic        i_init_done,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [2:0]  o_err_code,
    output logic [7:0]  o_data,
    output logic        o_data_valid,
    output logic        o_cmd_we,
    output logic [7:0]  o_cmd,
    output logic [31:0] o_arg,
    output logic [7:0]  o_crc,
    input  logic        i_cmd_done,
    output logic        o_rcv_we,
    input  logic        i_rcv_done,
    input  logic [7:0]  i_rcv_res,
    output logic        o_cs,
    output logic [1:0]  o_sel
);

    sdc_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             cnt_inc;
    logic             r1_last;
    logic             tok_last;
    logic             blk_last;
    logic             crc_last;
    logic             rcv_req;
    logic             fail;
    sdc_err_t         fail_code;

    sdc_poll_cnt #(
        .R1_TRIES    (R1_TRIES),
        .TOKEN_TRIES (TOKEN_TRIES),
        .BLOCK_LEN   (BLOCK_LEN),
        .CNT_W       (CNT_W)
    ) u_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (cnt_clr),
        .i_inc      (cnt_inc),
        .o_cnt      (cnt),
        .o_r1_last  (r1_last),
        .o_tok_last (tok_last),
        .o_blk_last (blk_last)
    );

    // Counter is cleared on DATA_WAIT exit, so after one CRC byte it reads 1.
    assign crc_last = (cnt == CNT_W'(1));

    always_comb begin
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        rcv_req   = 1'b0;
        fail      = 1'b0;
        fail_code = ERR_NONE;
        case (state)
            ST_IDLE:     cnt_clr = i_start && i_init_done;
            ST_CMD_WAIT: rcv_req = i_cmd_done;
            ST_R1_WAIT: begin
                if (i_rcv_done) begin
                    if (i_rcv_res == SD_R1_READY) begin
                        cnt_clr = 1'b1;
                        rcv_req = 1'b1;
                    end else if (i_rcv_res == SD_IDLE_BYTE) begin
                        cnt_inc = 1'b1;
                        if (r1_last) begin
                            fail      = 1'b1;
                            fail_code = ERR_R1_TIMEOUT;
                        end else begin
                            rcv_req = 1'b1;
                        end
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_BAD_R1;
                    end
                end
            end
            ST_TOK_WAIT: begin
                if (i_rcv_done) begin
                    if (i_rcv_res == SD_TOKEN_START) begin
                        cnt_clr = 1'b1;
                        rcv_req = 1'b1;
                    end else if (i_rcv_res == SD_IDLE_BYTE) begin
                        cnt_inc = 1'b1;
                        if (tok_last) begin
                            fail      = 1'b1;
                            fail_code = ERR_TOK_TIMEOUT;
                        end else begin
                            rcv_req = 1'b1;
                        end
                    end else begin
                        fail      = 1'b1;
                        fail_code = ERR_DATA_TOKEN;
                    end
                end
            end
            ST_DATA_WAIT: begin
                if (i_rcv_done) begin
                    rcv_req = 1'b1;
                    cnt_clr = blk_last;
                    cnt_inc = !blk_last;
                end
            end
            ST_CRC_WAIT: begin
                if (i_rcv_done) begin
                    cnt_inc = 1'b1;
                    rcv_req = !crc_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_err_code   <= ERR_NONE;
            o_data       <= 8'h00;
            o_data_valid <= 1'b0;
            o_cmd_we     <= 1'b0;
            o_cmd        <= 8'hFF;
            o_arg        <= '1;
            o_crc        <= 8'hFF;
            o_rcv_we     <= 1'b0;
            o_cs         <= 1'b1;
            o_sel        <= 2'd0;
        end else begin
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_data_valid <= 1'b0;
            o_cmd_we     <= 1'b0;
            o_rcv_we     <= rcv_req;
            if (fail) begin
                state      <= ST_ERR;
                o_err      <= 1'b1;
                o_err_code <= fail_code;
                o_cs       <= 1'b1;
                o_sel      <= 2'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (i_start && i_init_done) begin
                            state      <= ST_CMD;
                            o_busy     <= 1'b1;
                            o_err_code <= ERR_NONE;
                            o_cmd_we   <= 1'b1;
                            o_cmd      <= SD_CMD17;
                            o_arg      <= i_addr;
                            o_crc      <= 8'hFF;
                            o_cs       <= 1'b0;
                            o_sel      <= 2'd1;
                        end else if (i_start) begin
                            o_err      <= 1'b1;
                            o_err_code <= ERR_NOT_INIT;
                        end
                    end
                    ST_CMD: state <= ST_CMD_WAIT;
                    ST_CMD_WAIT: begin
                        if (i_cmd_done) begin
                            state <= ST_R1_WAIT;
                            o_sel <= 2'd2;
                        end
                    end
                    ST_R1_WAIT: begin
                        if (i_rcv_done && i_rcv_res == SD_R1_READY) state <= ST_TOK_WAIT;
                    end
                    ST_TOK_WAIT: begin
                        if (i_rcv_done && i_rcv_res == SD_TOKEN_START) state <= ST_DATA_WAIT;
                    end
                    ST_DATA_WAIT: begin
                        if (i_rcv_done) begin
                            o_data       <= i_rcv_res;
                            o_data_valid <= 1'b1;
                            if (blk_last) state <= ST_CRC_WAIT;
                        end
                    end
                    ST_CRC_WAIT: begin
                        if (i_rcv_done && crc_last) begin
                            state  <= ST_DONE;
                            o_done <= 1'b1;
                            o_cs   <= 1'b1;
                            o_sel  <= 2'd0;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                        o_cmd  <= 8'hFF;
                        o_arg  <= '1;
                        o_crc  <= 8'hFF;
                        o_cs   <= 1'b1;
                        o_sel  <= 2'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdc_read_ctrl.sv
// Randomised bench for sdc_read_ctrl: emulated card and engines, with a
// transaction-level model predicting outcome, error code and byte counts.
module tb_sdc_read_ctrl;

    localparam int R1_TRIES    = 8;
    localparam int TOKEN_TRIES = 16;
    localparam int BLOCK_LEN   = 512;

    logic        i_clk;
    logic        i_rst;
    logic        i_start;
    logic [31:0] i_addr;
    logic        i_init_done;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic [2:0]  o_err_code;
    logic [7:0]  o_data;
    logic        o_data_valid;
    logic        o_cmd_we;
    logic [7:0]  o_cmd;
    logic [31:0] o_arg;
    logic [7:0]  o_crc;
    logic        i_cmd_done;
    logic        o_rcv_we;
    logic        i_rcv_done;
    logic [7:0]  i_rcv_res;
    logic        o_cs;
    logic [1:0]  o_sel;

    sdc_read_ctrl #(
        .R1_TRIES    (R1_TRIES),
        .TOKEN_TRIES (TOKEN_TRIES),
        .BLOCK_LEN   (BLOCK_LEN),
        .CNT_W       (13)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_addr       (i_addr),
        .i_init_done  (i_init_done),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_err_code   (o_err_code),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_cmd_we     (o_cmd_we),
        .o_cmd        (o_cmd),
        .o_arg        (o_arg),
        .o_crc        (o_crc),
        .i_cmd_done   (i_cmd_done),
        .o_rcv_we     (o_rcv_we),
        .i_rcv_done   (i_rcv_done),
        .i_rcv_res    (i_rcv_res),
        .o_cs         (o_cs),
        .o_sel        (o_sel)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Card byte stream and bytes expected on the data strobe.
    logic [7:0] resp_q[$];
    logic [7:0] exp_data_q[$];

    int pend_cmd = -1;
    int pend_rcv = -1;
    int cmd_we_cnt = 0;
    int rcv_we_cnt = 0;
    int data_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int overlap_cnt = 0;
    int bus_bad = 0;
    logic [2:0]  last_code = '0;
    logic [7:0]  last_cmd = '0;
    logic [31:0] last_arg = '0;
    logic [7:0]  last_crc = '0;

    // Engine emulation and output monitor, all on the falling edge.
    initial begin
        i_cmd_done = 1'b0;
        i_rcv_done = 1'b0;
        i_rcv_res  = 8'h00;
        forever begin
            @(negedge i_clk);
            i_cmd_done = 1'b0;
            i_rcv_done = 1'b0;
            i_rcv_res  = 8'($urandom);
            if (pend_cmd > 0) begin
                pend_cmd--;
                if (pend_cmd == 0) begin
                    i_cmd_done = 1'b1;
                    pend_cmd   = -1;
                end
            end
            if (pend_rcv > 0) begin
                pend_rcv--;
                if (pend_rcv == 0) begin
                    i_rcv_done = 1'b1;
                    i_rcv_res  = (resp_q.size() > 0) ? resp_q.pop_front() : 8'hFF;
                    pend_rcv   = -1;
                end
            end
            // Stray handshakes while the DUT waits on the other engine or idles.
            if ($urandom_range(0, 7) == 0) begin
                if (pend_rcv > 0 || (!o_busy && !i_rst)) i_cmd_done = 1'b1;
                if (pend_cmd > 0 || (!o_busy && !i_rst)) i_rcv_done = 1'b1;
            end
            if (o_cmd_we) begin
                cmd_we_cnt++;
                if (pend_cmd >= 0 || pend_rcv >= 0) overlap_cnt++;
                if (o_cs !== 1'b0 || o_sel !== 2'd1) bus_bad++;
                last_cmd = o_cmd;
                last_arg = o_arg;
                last_crc = o_crc;
                pend_cmd = 1 + $urandom_range(0, 3);
            end
            if (o_rcv_we) begin
                rcv_we_cnt++;
                if (pend_cmd >= 0 || pend_rcv >= 0) overlap_cnt++;
                if (o_cs !== 1'b0 || o_sel !== 2'd2) bus_bad++;
                pend_rcv = 1 + $urandom_range(0, 2);
            end
            if (o_data_valid) begin
                data_cnt++;
                if (exp_data_q.size() > 0) check_eq("data", o_data, exp_data_q.pop_front());
                else check_eq("data_extra", o_data_valid, 1'b0);
            end
            if (o_done) done_cnt++;
            if (o_err) begin
                err_cnt++;
                last_code = o_err_code;
            end
            if ((!o_busy || o_done || o_err) && o_cs !== 1'b1) bus_bad++;
        end
    end

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_busy"}, o_busy, 1'b0);
        check_eq({tag, "_cs"}, o_cs, 1'b1);
        check_eq({tag, "_sel"}, o_sel, 2'd0);
        check_eq({tag, "_done_err"}, {o_done, o_err, o_data_valid, o_cmd_we, o_rcv_we}, 5'd0);
        check_eq({tag, "_code"}, o_err_code, 3'd0);
        check_eq({tag, "_data"}, o_data, 8'h00);
        check_eq({tag, "_cmd"}, o_cmd, 8'hFF);
        check_eq({tag, "_arg"}, o_arg, 32'hFFFF_FFFF);
        check_eq({tag, "_crc"}, o_crc, 8'hFF);
    endtask

    task automatic tick();
        @(negedge i_clk);
        #1;
    endtask

    task automatic run_txn(input logic [31:0] addr, input bit init, input int nr1,
                           input logic [7:0] r1, input int ntok, input logic [7:0] tok,
                           input bit rand_data, input int reset_at);
        bit exp_ok;
        int exp_code, exp_rcv, exp_cmd, b_done, b_err, b_rcv, b_cmd, b_data, b_ovl, b_bus;
        bit ended;
        logic [7:0] b;
        resp_q.delete();
        exp_data_q.delete();
        for (int i = 0; i < nr1; i++) resp_q.push_back(8'hFF);
        resp_q.push_back(r1);
        for (int i = 0; i < ntok; i++) resp_q.push_back(8'hFF);
        resp_q.push_back(tok);
        exp_ok = 1'b0;
        exp_cmd = init ? 1 : 0;
        if (!init) begin
            exp_code = 1; exp_rcv = 0;
        end else if (nr1 >= R1_TRIES) begin
            exp_code = 3; exp_rcv = R1_TRIES;
        end else if (r1 != 8'h00) begin
            exp_code = 2; exp_rcv = nr1 + 1;
        end else if (ntok >= TOKEN_TRIES) begin
            exp_code = 5; exp_rcv = nr1 + 1 + TOKEN_TRIES;
        end else if (tok != 8'hFE) begin
            exp_code = 4; exp_rcv = nr1 + 1 + ntok + 1;
        end else begin
            exp_ok = 1'b1; exp_code = 0; exp_rcv = nr1 + 1 + ntok + 1 + BLOCK_LEN + 2;
        end
        for (int i = 0; i < BLOCK_LEN; i++) begin
            b = rand_data ? 8'($urandom) : 8'(i);
            resp_q.push_back(b);
            if (exp_ok) exp_data_q.push_back(b);
        end
        resp_q.push_back(8'($urandom));
        resp_q.push_back(8'($urandom));
        b_done = done_cnt; b_err = err_cnt; b_rcv = rcv_we_cnt; b_cmd = cmd_we_cnt;
        b_data = data_cnt; b_ovl = overlap_cnt; b_bus = bus_bad;
        i_addr = addr;
        i_init_done = init;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_addr = $urandom;
        ended = 1'b0;
        for (int cyc = 0; cyc < 20000 && !ended; cyc++) begin
            if (reset_at > 0 && data_cnt - b_data == reset_at) begin
                #1 i_rst = 1'b1;
                #1 check_reset_values("midrst");
                resp_q.delete();
                exp_data_q.delete();
                pend_cmd = -1;
                pend_rcv = -1;
                tick();
                tick();
                i_rst = 1'b0;
                tick();
                tick();
                check_eq("midrst_no_pulse", (done_cnt - b_done) + (err_cnt - b_err), 0);
                check_eq("midrst_bus", bus_bad - b_bus, 0);
                return;
            end
            if (done_cnt != b_done || err_cnt != b_err) begin
                ended = 1'b1;
            end else begin
                if (cyc == 3 && o_busy) i_start = 1'b1;
                if (cyc == 7 && init && $urandom_range(0, 1) == 1) i_init_done = 1'b0;
                tick();
                i_start = 1'b0;
            end
        end
        check_eq("timeout", ended, 1'b1);
        repeat (3) tick();
        check_eq("done_pulses", done_cnt - b_done, exp_ok ? 1 : 0);
        check_eq("err_pulses", err_cnt - b_err, exp_ok ? 0 : 1);
        if (!exp_ok) check_eq("err_code_pulse", last_code, exp_code);
        check_eq("err_code_held", o_err_code, exp_code);
        check_eq("rcv_count", rcv_we_cnt - b_rcv, exp_rcv);
        check_eq("cmd_we_count", cmd_we_cnt - b_cmd, exp_cmd);
        check_eq("data_strobes", data_cnt - b_data, exp_ok ? BLOCK_LEN : 0);
        check_eq("data_left", exp_data_q.size(), 0);
        if (init) check_eq("cmd_frame", {last_cmd, last_arg, last_crc}, {8'h51, addr, 8'hFF});
        check_eq("overlap", overlap_cnt - b_ovl, 0);
        check_eq("bus", bus_bad - b_bus, 0);
        check_eq("idle_state", {o_busy, o_cs, o_sel}, 4'b0100);
    endtask

    initial begin
        i_rst = 1'b1;
        i_start = 1'b0;
        i_addr = '0;
        i_init_done = 1'b0;
        #12;
        check_reset_values("reset");
        #13;
        i_rst = 1'b0;
        tick();

        run_txn(32'h0000_0010, 1'b1, 0, 8'h00, 2, 8'hFE, 1'b0, 0);
        run_txn(32'h0000_1234, 1'b1, 7, 8'h00, 0, 8'hFE, 1'b0, 0);
        run_txn(32'h0000_0001, 1'b1, 8, 8'h00, 0, 8'hFE, 1'b0, 0);
        run_txn(32'h0000_0002, 1'b1, 0, 8'h05, 0, 8'hFE, 1'b0, 0);
        run_txn(32'h0000_0003, 1'b1, 1, 8'h00, 3, 8'h09, 1'b0, 0);
        run_txn(32'h0000_0004, 1'b1, 0, 8'h00, 16, 8'hFE, 1'b0, 0);
        run_txn(32'h0000_0005, 1'b1, 0, 8'h00, 15, 8'hFE, 1'b1, 0);
        run_txn(32'h0000_0006, 1'b0, 0, 8'h00, 0, 8'hFE, 1'b0, 0);
        run_txn(32'hDEAD_BEEF, 1'b1, 2, 8'h00, 4, 8'hFE, 1'b1, 100);
        run_txn(32'hCAFE_0042, 1'b1, 1, 8'h00, 1, 8'hFE, 1'b0, 0);

        for (int t = 0; t < 20; t++) begin
            logic [7:0] r1v, tokv;
            r1v  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 254)) : 8'h00;
            tokv = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 253)) : 8'hFE;
            run_txn($urandom, ($urandom_range(0, 9) != 0), $urandom_range(0, 9), r1v,
                    $urandom_range(0, 18), tokv, 1'b1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sdc_read_ctrl.md
Name: sdc_read_ctrl

Overview:
- Single-block read sequencer (CMD17) for the SPI SD card path. Runs after initialisation completes.
- Sequences the existing command-transmit engine and byte-receive engine through we/done handshakes.
- Owns chip select and the SPI source-select for the bus mux.
- Streams the 512 data bytes to a consumer, discards the CRC, and reports done or a coded error.

Parameters:
- R1_TRIES, 8: maximum receive bytes polled for the R1 response (0xFF = busy/no response).
- TOKEN_TRIES, 4096: maximum receive bytes polled for the start token 0xFE.
- BLOCK_LEN, 512: data bytes per block.
- CNT_W, 13: width of the shared poll/byte counter; must satisfy 2^CNT_W > max(TOKEN_TRIES, BLOCK_LEN).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; asynchronous, active-high
- i_start  in  1  read request; sampled only in IDLE
- i_addr  in  32  block address; latched on accepted start
- i_init_done  in  1  level; card initialised
- o_busy  out  1  high from accepted start until return to IDLE
- o_done  out  1  one-cycle pulse; block read OK
- o_err  out  1  one-cycle pulse; read failed
- o_err_code  out  3  error cause; held until next accepted start
- o_data  out  8  received data byte
- o_data_valid  out  1  one-cycle strobe per data byte
- o_cmd_we  out  1  one-cycle pulse; starts the command engine
- o_cmd  out  8  command byte
- o_arg  out  32  command argument
- o_crc  out  8  command CRC byte
- i_cmd_done  in  1  one-cycle pulse; command frame sent
- o_rcv_we  out  1  one-cycle pulse; starts the receive engine
- i_rcv_done  in  1  one-cycle pulse; byte received
- i_rcv_res  in  8  received byte; valid while i_rcv_done=1
- o_cs  out  1  SD chip select, active-low
- o_sel  out  2  bus mux select: 0=idle (mosi=1), 1=cmd engine, 2=rcv engine

Behaviour:
Reset values:
- o_busy, o_done, o_err, o_data_valid, o_cmd_we, o_rcv_we = 0.
- o_cs = 1; o_sel = 0; o_err_code = 0; o_data = 8'h00.
- o_cmd = 8'hFF; o_arg = 32'hFFFFFFFF; o_crc = 8'hFF.
- State IDLE; counter cleared.

States and transitions:
- IDLE:
  - i_start & i_init_done: latch i_addr, clear o_err_code and counter, go CMD.
  - i_start & !i_init_done: o_err pulse next cycle, code 1, no bus activity, stay IDLE.
- CMD: assert o_cmd_we for one cycle with o_cmd=8'h51, o_arg=latched address, o_crc=8'hFF; o_cs=0, o_sel=1; go CMD_WAIT.
- CMD_WAIT: on i_cmd_done, pulse o_rcv_we, set o_sel=2, go R1_WAIT.
- R1_WAIT: on i_rcv_done:
  - 8'h00: clear counter, pulse o_rcv_we, go TOK_WAIT.
  - 8'hFF: increment counter; if counter reaches R1_TRIES, go ERR with code 3; otherwise pulse o_rcv_we again.
  - Any other value: go ERR with code 2.
- TOK_WAIT: on i_rcv_done:
  - 8'hFE: clear counter, pulse o_rcv_we, go DATA_WAIT.
  - 8'hFF: increment counter; if counter reaches TOKEN_TRIES, go ERR with code 5; otherwise re-pulse o_rcv_we.
  - Any other value (data error token): go ERR with code 4.
- DATA_WAIT: on i_rcv_done, register o_data=i_rcv_res and o_data_valid=1 for exactly one cycle, increment counter, then:
  - counter reaches BLOCK_LEN: clear counter, go CRC_WAIT.
  - otherwise re-pulse o_rcv_we.
  - In both cases o_rcv_we is pulsed in the same cycle.
- CRC_WAIT: two received bytes are discarded; after the second i_rcv_done, go DONE.
- DONE: o_done=1 for one cycle; o_cs=1, o_sel=0; go IDLE.
- ERR: o_err=1 for one cycle; o_cs=1, o_sel=0; go IDLE.

Rules:
- o_cs=0 from CMD through CRC_WAIT inclusive; 1 in all other states.
- o_busy=1 in every state except IDLE.
- At most one we pulse is outstanding at any time.
- i_cmd_done / i_rcv_done arriving in any state that is not waiting for that engine are ignored.
- i_start while busy is ignored (not queued).
- i_init_done falling mid-operation has no effect until the next start.
- i_rst mid-operation: immediate return to IDLE with all reset values, no done/err pulse, o_cs=1 in the same cycle (asynchronous).
- Counter increments saturate-free within CNT_W; comparisons use equality with the parameter values.
- Error codes: 0 none, 1 not initialised, 2 bad R1, 3 R1 timeout, 4 data error token, 5 token timeout.

Decomposition:
- Shared package sdc_pkg holds:
  - State encoding.
  - CMD17 opcode 8'h51.
  - Token 8'hFE and idle byte 8'hFF.
  - Error-code constants.
- Command opcodes should be moved there for reuse by the init and write sequencers.
- One natural sub-module: sdc_poll_cnt, the counter with clear/increment and terminal-compare outputs for R1_TRIES, TOKEN_TRIES and BLOCK_LEN.

Test Plan:
- Normal read: addr 32'h0000_0010; R1 0x00; two 0xFF then 0xFE; data bytes = index mod 256.
  -> o_cmd 8'h51, o_arg 32'h10; 512 o_data_valid strobes with matching o_data; two CRC bytes consumed; o_done once; o_cs returns 1.
- R1 polling: seven 0xFF then 0x00 -> read proceeds. Eight 0xFF -> o_err, code 3, no data strobes.
- R1 = 8'h05 -> o_err, code 2, exactly one receive after the command.
- Token: 8'h09 -> o_err, code 4. With TOKEN_TRIES=16 and continuous 0xFF -> code 5 after exactly 16 receives.
- Start with i_init_done=0 -> o_err, code 1; o_cmd_we never asserted; o_cs stays 1.
- i_rst asserted after 100 data bytes -> all outputs at reset values immediately. A following start with a good card completes with o_done and a full 512 bytes.
